// File: rtl/woz_track_reader.sv
// Streams one WOZ track from BRAM as a timed MSB-first bitstream.
// Each byte is fetched once, with a one-byte prefetch buffer. The track wraps at track_bits.
module woz_track_reader #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned POS_W      = 16,
    parameter int unsigned BIT_CYCLES = 28
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_motor_on,
    input  logic              i_track_valid,
    input  logic [ADDR_W-1:0] i_track_base,
    input  logic [POS_W-1:0]  i_track_bits,
    output logic              o_ram_rd,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [7:0]        i_ram_q,
    output logic              o_bit_out,
    output logic              o_bit_strobe,
    output logic              o_index_pulse,
    output logic [POS_W-1:0]  o_bit_pos,
    output logic              o_ready
);

    localparam int unsigned CNT_W  = $clog2(BIT_CYCLES);
    localparam int unsigned POSX_W = POS_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [7:0]          r_shift, w_shift;
    logic [7:0]          r_next_byte, w_next_byte;
    logic                r_next_valid, w_next_valid;
    logic                r_cap_pend, w_cap_pend;
    logic                r_ram_rd, w_ram_rd;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
    logic                r_bit_out, w_bit_out;
    logic                r_strobe, w_strobe;
    logic                r_index, w_index;
    logic [POS_W-1:0]    r_bit_pos, w_bit_pos;
    logic                r_ready, w_ready;

    logic [POS_W-1:0]    w_bp1;
    logic                w_last;
    logic [POS_W-1:0]    w_new_pos;
    logic                w_boundary;
    logic [POSX_W-1:0]   w_nstart_full;
    logic [POS_W-1:0]    w_nstart;
    logic [POS_W-1:0]    w_idle_pos;

    // Position arithmetic for the bit about to be emitted
    assign w_bp1         = r_bit_pos + POS_W'(1);
    assign w_last        = (w_bp1 == i_track_bits);
    assign w_new_pos     = w_last ? POS_W'(0) : w_bp1;
    assign w_boundary    = (r_bit_pos[2:0] == 3'd7) || w_last;
    assign w_nstart_full = POSX_W'({r_bit_pos[POS_W-1:3], 3'b000}) + POSX_W'(8);
    assign w_nstart      = (w_nstart_full >= {1'b0, i_track_bits}) ? POS_W'(0)
                                                                   : POS_W'(w_nstart_full);
    assign w_idle_pos    = (r_bit_pos >= i_track_bits) ? POS_W'(0) : r_bit_pos;

    // Next-state and next-output logic
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_shift      = r_shift;
        w_next_byte  = r_next_byte;
        w_next_valid = r_next_valid;
        w_cap_pend   = r_ram_rd && (r_state == ST_RUN);
        w_ram_rd     = 1'b0;
        w_ram_addr   = r_ram_addr;
        w_bit_out    = r_bit_out;
        w_strobe     = 1'b0;
        w_index      = 1'b0;
        w_bit_pos    = r_bit_pos;

        // Prefetched byte arrives one cycle after its read strobe
        if (r_cap_pend) begin
            w_next_byte  = i_ram_q;
            w_next_valid = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (i_track_valid && (i_track_bits != POS_W'(0))) begin
                    w_bit_pos  = w_idle_pos;
                    w_state    = ST_FETCH;
                    w_ram_rd   = 1'b1;
                    w_ram_addr = i_track_base + ADDR_W'(w_idle_pos >> 3);
                end
            end
            ST_FETCH: begin
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_shift = 8'(i_ram_q << r_bit_pos[2:0]);
                w_cnt   = '0;
                w_state = ST_RUN;
            end
            ST_RUN: begin
                if (!i_motor_on) begin
                    w_state = ST_PAUSE;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt     = '0;
                    w_strobe  = 1'b1;
                    w_bit_out = r_shift[7];
                    w_index   = (r_bit_pos == POS_W'(0));
                    w_shift   = {r_shift[6:0], 1'b0};
                    w_bit_pos = w_new_pos;
                    if ((r_bit_pos[2:0] == 3'd3) && !w_boundary) begin
                        w_ram_rd   = 1'b1;
                        w_ram_addr = i_track_base + ADDR_W'(w_nstart >> 3);
                    end
                    if (w_boundary) begin
                        w_next_valid = 1'b0;
                        if (r_next_valid) begin
                            w_shift = r_next_byte;
                        end else begin
                            // Buffer empty: refetch the byte that starts at the new position
                            w_state    = ST_FETCH;
                            w_ram_rd   = 1'b1;
                            w_ram_addr = i_track_base + ADDR_W'(w_new_pos >> 3);
                        end
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (i_motor_on) begin
                    w_state = ST_RUN;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Losing the track aborts everything but keeps the head position
        if (!i_track_valid) begin
            w_state      = ST_IDLE;
            w_cnt        = '0;
            w_shift      = r_shift;
            w_next_valid = 1'b0;
            w_cap_pend   = 1'b0;
            w_ram_rd     = 1'b0;
            w_ram_addr   = r_ram_addr;
            w_bit_out    = r_bit_out;
            w_strobe     = 1'b0;
            w_index      = 1'b0;
            w_bit_pos    = r_bit_pos;
        end

        w_ready = (w_state == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_next_byte  <= '0;
            r_next_valid <= 1'b0;
            r_cap_pend   <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_ram_addr   <= '0;
            r_bit_out    <= 1'b0;
            r_strobe     <= 1'b0;
            r_index      <= 1'b0;
            r_bit_pos    <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_shift      <= w_shift;
            r_next_byte  <= w_next_byte;
            r_next_valid <= w_next_valid;
            r_cap_pend   <= w_cap_pend;
            r_ram_rd     <= w_ram_rd;
            r_ram_addr   <= w_ram_addr;
            r_bit_out    <= w_bit_out;
            r_strobe     <= w_strobe;
            r_index      <= w_index;
            r_bit_pos    <= w_bit_pos;
            r_ready      <= w_ready;
        end
    end

    assign o_ram_rd      = r_ram_rd;
    assign o_ram_addr    = r_ram_addr;
    assign o_bit_out     = r_bit_out;
    assign o_bit_strobe  = r_strobe;
    assign o_index_pulse = r_index;
    assign o_bit_pos     = r_bit_pos;
    assign o_ready       = r_ready;

endmodule

// File: tb/tb_woz_track_reader.sv
// Bench for woz_track_reader: BRAM model, bit-stream scoreboard, strobe spacing monitor.
module tb_woz_track_reader;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned POS_W  = 16;
    localparam int unsigned BITC   = 28;

    logic              clk;
    logic              i_reset;
    logic              i_motor_on;
    logic              i_track_valid;
    logic [ADDR_W-1:0] i_track_base;
    logic [POS_W-1:0]  i_track_bits;
    logic              o_ram_rd;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [7:0]        ram_q;
    logic              o_bit_out;
    logic              o_bit_strobe;
    logic              o_index_pulse;
    logic [POS_W-1:0]  o_bit_pos;
    logic              o_ready;

    woz_track_reader #(.ADDR_W(ADDR_W), .POS_W(POS_W), .BIT_CYCLES(BITC)) dut (
        .i_clk_sys    (clk),
        .i_reset      (i_reset),
        .i_motor_on   (i_motor_on),
        .i_track_valid(i_track_valid),
        .i_track_base (i_track_base),
        .i_track_bits (i_track_bits),
        .o_ram_rd     (o_ram_rd),
        .o_ram_addr   (o_ram_addr),
        .i_ram_q      (ram_q),
        .o_bit_out    (o_bit_out),
        .o_bit_strobe (o_bit_strobe),
        .o_index_pulse(o_index_pulse),
        .o_bit_pos    (o_bit_pos),
        .o_ready      (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track buffer with one-cycle registered read
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (o_ram_rd) ram_q <= mem[o_ram_addr];
    end

    typedef struct {
        logic             b;
        logic             idx;
        logic [POS_W-1:0] pos;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [POS_W-1:0]  tbits;
        logic [23:0]       data;
        int                n_emit;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_evt = 0;
    logic prev_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bit_at(input logic [ADDR_W-1:0] base, input int p);
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        a = base + ADDR_W'(p / 8);
        d = mem[a];
        return d[7 - (p % 8)];
    endfunction

    task automatic push_bits(input logic [ADDR_W-1:0] base, input int start, input int count,
                             input int tbits);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            int p;
            p     = (start + k) % tbits;
            e.b   = bit_at(base, p);
            e.idx = (p == 0);
            e.pos = POS_W'((p + 1) % tbits);
            sb.push_back(e);
        end
    endtask

    task automatic load_bytes(input logic [ADDR_W-1:0] base, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        mem[base]                 = b0;
        mem[base + ADDR_W'(1)]    = b1;
        mem[base + ADDR_W'(2)]    = b2;
    endtask

    task automatic wait_drain(input int maxc);
        int c;
        c = 0;
        while (sb.size() != 0 && c < maxc) begin
            @(negedge clk); #1;
            c++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_a", {o_ram_rd, o_ram_addr, o_bit_out, o_bit_strobe, o_index_pulse}, 64'd0);
        check("rst_b", {o_bit_pos, o_ready}, 64'd0);
    endtask

    task automatic do_reset();
        i_reset       = 1'b1;
        i_track_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs();
        sb.delete();
        i_reset = 1'b0;
    endtask

    // Scoreboard pop, index sanity and strobe spacing (from previous strobe or RUN entry)
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (o_index_pulse && !o_bit_strobe) check("idx_no_strobe", 64'd1, 64'd0);
        if (o_bit_strobe) begin
            if (sb.size() == 0) begin
                check("unexp_strobe", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("bit_idx_pos", {o_bit_out, o_index_pulse, o_bit_pos}, {e.b, e.idx, e.pos});
            end
            check("gap", 64'(cyc - last_evt), 64'(BITC));
            last_evt = cyc;
        end
        if (o_ready && !prev_ready) last_evt = cyc;
        prev_ready = o_ready;
    end

    vec_t vec [4];

    initial begin
        i_reset       = 1'b1;
        i_motor_on    = 1'b0;
        i_track_valid = 1'b0;
        i_track_base  = '0;
        i_track_bits  = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);

        vec[0] = '{base: 13'h100,  tbits: 16'd24, data: 24'hD5AA96, n_emit: 26};
        vec[1] = '{base: 13'h1FFF, tbits: 16'd24, data: 24'h3CC3E7, n_emit: 26};
        vec[2] = '{base: 13'h040,  tbits: 16'd20, data: 24'hFF00AB, n_emit: 44};
        vec[3] = '{base: 13'h200,  tbits: 16'd13, data: 24'h3C5A00, n_emit: 30};

        // Table: full streams with wrap, address wrap, partial last bytes
        for (int v = 0; v < 4; v++) begin
            logic [23:0] d;
            do_reset();
            d = vec[v].data;
            load_bytes(vec[v].base, d[23:16], d[15:8], d[7:0]);
            i_track_base  = vec[v].base;
            i_track_bits  = vec[v].tbits;
            i_motor_on    = 1'b1;
            i_track_valid = 1'b1;
            push_bits(vec[v].base, 0, vec[v].n_emit, int'(vec[v].tbits));
            wait_drain(vec[v].n_emit * 40 + 200);
        end

        // Motor pause at bit_pos 13
        do_reset();
        load_bytes(13'h100, 8'hD5, 8'hAA, 8'h96);
        i_track_base  = 13'h100;
        i_track_bits  = 16'd24;
        i_motor_on    = 1'b1;
        i_track_valid = 1'b1;
        push_bits(13'h100, 0, 13, 24);
        wait_drain(13 * 40 + 200);
        i_motor_on = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("pause_pos", 64'(o_bit_pos), 64'd13);
        check("pause_ready", 64'(o_ready), 64'd0);
        push_bits(13'h100, 13, 13, 24);
        i_motor_on = 1'b1;
        wait_drain(13 * 40 + 200);

        // Track change at bit_pos 30 onto a shorter track
        do_reset();
        mem[13'h300] = 8'h12; mem[13'h301] = 8'h34; mem[13'h302] = 8'h56;
        mem[13'h303] = 8'h78; mem[13'h304] = 8'h9A;
        i_track_base  = 13'h300;
        i_track_bits  = 16'd40;
        i_motor_on    = 1'b1;
        i_track_valid = 1'b1;
        push_bits(13'h300, 0, 30, 40);
        wait_drain(30 * 40 + 200);
        i_track_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("drop_hold", {o_bit_pos, o_ready}, {16'd30, 1'b0});
        load_bytes(13'h380, 8'hC3, 8'hA5, 8'h00);
        i_track_base  = 13'h380;
        i_track_bits  = 16'd16;
        i_track_valid = 1'b1;
        @(negedge clk); #1;
        check("reload_fetch", {o_ram_rd, o_ram_addr, o_bit_pos}, {1'b1, 13'h380, 16'd0});
        push_bits(13'h380, 0, 18, 16);
        wait_drain(18 * 40 + 200);

        // Reset while a prefetch read is on the bus
        do_reset();
        load_bytes(13'h100, 8'hD5, 8'hAA, 8'h96);
        i_track_base  = 13'h100;
        i_track_bits  = 16'd24;
        i_motor_on    = 1'b1;
        i_track_valid = 1'b1;
        push_bits(13'h100, 0, 4, 24);
        wait_drain(4 * 40 + 200);
        check("prefetch_rd", {o_ram_rd, o_ram_addr}, {1'b1, 13'h101});
        i_reset = 1'b1;
        @(negedge clk); #1;
        check_reset_outputs();
        i_reset       = 1'b0;
        i_track_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("post_reset_idle", {o_ready, o_ram_rd, o_bit_pos}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
